// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usb_pkg
//  Purpose  : Shared definitions for the USB endpoint arbiter: FSM state
//             encoding, sizing constants and a modular-increment helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } usb_arb_state_e;

    localparam int USB_ARB_MAX_EP = 8;
    localparam int USB_ARB_CNT_W  = 8;

    // (idx + 1) mod n, for idx < n <= 8.
    function automatic logic [2:0] usb_arb_wrap_inc(input logic [2:0] idx, input int n);
        logic [3:0] nxt;
        nxt = {1'b0, idx} + 4'd1;
        if (nxt >= 4'(n)) begin
            nxt = 4'd0;
        end
        return nxt[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : usb_rr_pick
//  Purpose  : Combinational round-robin picker. Returns the first set bit of
//             req_i at or above ptr_i, wrapping from NUM_EP-1 back to 0.
//  Ports    : req_i   - eligible request vector
//             ptr_i   - round-robin start index
//             idx_o   - winner index (0 when no request)
//             valid_o - at least one eligible request present
//  Revision : 1.0 - initial release
// ============================================================================
module usb_rr_pick
    import usb_pkg::*;
#(
    parameter int NUM_EP = 3
) (
    input  logic [NUM_EP-1:0] req_i,
    input  logic [2:0]        ptr_i,
    output logic [2:0]        idx_o,
    output logic              valid_o
);

    logic [USB_ARB_MAX_EP-1:0] req_pad;
    logic [3:0]                pos;

    // Scan offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        req_pad = USB_ARB_MAX_EP'(req_i);
        idx_o   = 3'd0;
        valid_o = 1'b0;
        pos     = 4'd0;
        for (int k = NUM_EP - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_i} + 4'(k);
            if (pos >= 4'(NUM_EP)) begin
                pos = pos - 4'(NUM_EP);
            end
            if (req_pad[pos[2:0]]) begin
                idx_o   = pos[2:0];
                valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_ep_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : usb_ep_arbiter
//  Purpose  : Round-robin arbiter granting one USB endpoint at a time access
//             to a shared packet buffer, forwarding the holder's byte strobe.
//             Optional build macro USB_ARB_TIMEOUT_EN adds an idle-hold
//             timeout that forcibly releases a silent holder.
//  Ports    : clk, reset  - clock, synchronous active-high reset
//             req         - per-requester access request
//             req_put     - per-requester byte write strobe
//             req_data    - per-requester byte, requester i on [8i+7:8i]
//             grant       - registered one-hot-or-zero grant
//             gnt_id      - current holder index (0 when idle)
//             busy        - high while a grant is held
//             buf_put     - write strobe to shared buffer
//             buf_data    - byte to shared buffer
//             timeout     - one-cycle pulse on forced release
//  Revision : 1.0 - initial release
// ============================================================================
module usb_ep_arbiter
    import usb_pkg::*;
#(
    parameter int NUM_EP  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EP-1:0]     req,
    input  logic [NUM_EP-1:0]     req_put,
    input  logic [8*NUM_EP-1:0]   req_data,
    output logic [NUM_EP-1:0]     grant,
    output logic [2:0]            gnt_id,
    output logic                  busy,
    output logic                  buf_put,
    output logic [7:0]            buf_data,
    output logic                  timeout
);

    if (NUM_EP < 2 || NUM_EP > USB_ARB_MAX_EP || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("usb_ep_arbiter: NUM_EP or TIMEOUT out of range");
    end

    usb_arb_state_e    state_q;
    logic [NUM_EP-1:0] grant_q;
    logic [2:0]        gnt_id_q;
    logic              busy_q;
    logic [2:0]        rr_ptr_q;
    logic [2:0]        rr_ptr_d;

    logic [NUM_EP-1:0] elig_req;
    logic [2:0]        pick_idx;
    logic              pick_valid;

    logic              hold_req;
    logic              hold_put;
    logic [7:0]        hold_data;

    // Select the current holder's lane; gnt_id is 0 when idle, so lane 0
    // drives buf_data then (buf_put is masked by busy).
    always_comb begin
        hold_req  = 1'b0;
        hold_put  = 1'b0;
        hold_data = 8'h00;
        for (int i = 0; i < NUM_EP; i++) begin
            if (gnt_id_q == 3'(i)) begin
                hold_req  = req[i];
                hold_put  = req_put[i];
                hold_data = req_data[8*i +: 8];
            end
        end
    end

`ifdef USB_ARB_TIMEOUT_EN
    localparam logic [USB_ARB_CNT_W-1:0] TIMEOUT_C = USB_ARB_CNT_W'(TIMEOUT);

    logic [USB_ARB_CNT_W-1:0] cnt_q;
    logic [USB_ARB_CNT_W-1:0] cnt_d;
    logic [NUM_EP-1:0]        mask_q;
    logic                     timeout_q;
    logic                     to_hit;

    assign cnt_d    = cnt_q + 8'd1;
    // A holder dropping req releases normally, even on the limit cycle.
    assign to_hit   = hold_req && !hold_put && (cnt_d == TIMEOUT_C);
    assign elig_req = req & mask_q;
    assign timeout  = timeout_q;
`else
    assign elig_req = req;
    assign timeout  = 1'b0;
`endif

    usb_rr_pick #(
        .NUM_EP (NUM_EP)
    ) u_pick (
        .req_i   (elig_req),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign rr_ptr_d = usb_arb_wrap_inc(pick_idx, NUM_EP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gnt_id_q <= 3'd0;
            busy_q   <= 1'b0;
            rr_ptr_q <= 3'd0;
`ifdef USB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            mask_q    <= '1;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef USB_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
            // A requester that lets go of req regains eligibility.
            for (int i = 0; i < NUM_EP; i++) begin
                if (!req[i]) begin
                    mask_q[i] <= 1'b1;
                end
            end
`endif
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= GRANT;
                        for (int i = 0; i < NUM_EP; i++) begin
                            grant_q[i] <= (pick_idx == 3'(i));
                        end
                        gnt_id_q <= pick_idx;
                        busy_q   <= 1'b1;
                        rr_ptr_q <= rr_ptr_d;
`ifdef USB_ARB_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!hold_req) begin
                        state_q  <= RELEASE;
                        grant_q  <= '0;
                        gnt_id_q <= 3'd0;
                        busy_q   <= 1'b0;
`ifdef USB_ARB_TIMEOUT_EN
                        cnt_q    <= '0;
                    end else if (to_hit) begin
                        state_q   <= RELEASE;
                        grant_q   <= '0;
                        gnt_id_q  <= 3'd0;
                        busy_q    <= 1'b0;
                        cnt_q     <= '0;
                        timeout_q <= 1'b1;
                        for (int i = 0; i < NUM_EP; i++) begin
                            if (gnt_id_q == 3'(i)) begin
                                mask_q[i] <= 1'b0;
                            end
                        end
                    end else begin
                        cnt_q <= hold_put ? '0 : cnt_d;
`endif
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign gnt_id   = gnt_id_q;
    assign busy     = busy_q;
    assign buf_put  = busy_q & hold_put;
    assign buf_data = hold_data;

endmodule
`default_nettype wire

// File: tb/tb_usb_ep_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_ep_arbiter
//  Purpose  : Self-checking bench for usb_ep_arbiter. A holder/pointer model
//             predicts every output each cycle; directed sequences add
//             literal expectations. A second NUM_EP=2 instance covers wrap.
//             Honours USB_ARB_TIMEOUT_EN (TIMEOUT=4 on the main instance).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb_ep_arbiter;

    localparam int N = 3;
`ifdef USB_ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_put;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   grant;
    logic [2:0]     gnt_id;
    logic           busy, buf_put, timeout;
    logic [7:0]     buf_data;

    logic [1:0]     req2, put2, grant2;
    logic [15:0]    data2;
    logic [2:0]     gnt_id2;
    logic           busy2, buf_put2, timeout2;
    logic [7:0]     buf_data2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    usb_ep_arbiter #(.NUM_EP(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_put(req_put), .req_data(req_data),
        .grant(grant), .gnt_id(gnt_id), .busy(busy), .buf_put(buf_put),
        .buf_data(buf_data), .timeout(timeout)
    );

    usb_ep_arbiter #(.NUM_EP(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .req_put(put2), .req_data(data2),
        .grant(grant2), .gnt_id(gnt_id2), .busy(busy2), .buf_put(buf_put2),
        .buf_data(buf_data2), .timeout(timeout2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model (main instance) ----------------
    // phase: 0 = no holder, 1 = holder owns buffer, 2 = dead cycle
    int       m_phase, m_hold, m_ptr, m_cnt, found, pos;
    bit       m_to;
    bit [N-1:0] m_elig, ne;
    bit       m_valid = 1'b0;
    int       e_idx;

    always @(negedge clk) begin
        if (m_valid) begin
            e_idx = (m_phase == 1) ? m_hold : 0;
            chk("m_grant",    32'(grant),    (m_phase == 1) ? (1 << m_hold) : 0);
            chk("m_gnt_id",   32'(gnt_id),   e_idx);
            chk("m_busy",     32'(busy),     (m_phase == 1) ? 1 : 0);
            chk("m_buf_put",  32'(buf_put),  (m_phase == 1 && req_put[m_hold]) ? 1 : 0);
            chk("m_buf_data", 32'(buf_data), (req_data >> (8 * e_idx)) & 24'hFF);
            chk("m_timeout",  32'(timeout),  32'(m_to));
        end
        if (reset) begin
            m_phase = 0; m_hold = 0; m_ptr = 0; m_cnt = 0;
            m_to = 1'b0; m_elig = '1; m_valid = 1'b1;
        end else if (m_valid) begin
            ne   = m_elig;
            m_to = 1'b0;
`ifdef USB_ARB_TIMEOUT_EN
            for (int i = 0; i < N; i++) if (!req[i]) ne[i] = 1'b1;
`endif
            case (m_phase)
                0: begin
                    found = -1;
                    for (int k = 0; k < N; k++) begin
                        pos = (m_ptr + k) % N;
                        if (found < 0 && req[pos] && m_elig[pos]) found = pos;
                    end
                    if (found >= 0) begin
                        m_phase = 1; m_hold = found; m_ptr = (found + 1) % N; m_cnt = 0;
                    end
                end
                1: begin
                    if (!req[m_hold]) begin
                        m_phase = 2; m_cnt = 0;
                    end
`ifdef USB_ARB_TIMEOUT_EN
                    else if (!req_put[m_hold] && m_cnt + 1 == TO) begin
                        m_phase = 2; m_to = 1'b1; ne[m_hold] = 1'b0; m_cnt = 0;
                    end
`endif
                    else begin
                        m_cnt = req_put[m_hold] ? 0 : m_cnt + 1;
                    end
                end
                default: m_phase = 0;
            endcase
            m_elig = ne;
        end
    end

    // ---------------- stimulus + literal expectations ----------------
    int ord[4] = '{0, 1, 2, 0};
    int ord2[3] = '{1, 0, 1};

    initial begin
        reset = 1'b1; req = '0; req_put = '0; req_data = '0;
        req2 = '0; put2 = '0; data2 = '0;
        tick(); tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_gnt_id", 32'(gnt_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout), 0);
        reset = 1'b0;

        // single requester, byte forwarded in the same cycle
        req = 3'b001; req_put = 3'b001; req_data = 24'h00005A;
        #1 chk("idle_put_ignored", 32'(buf_put), 0);
        tick();
        chk("g0_grant", 32'(grant), 3'b001);
        chk("g0_id", 32'(gnt_id), 0);
        chk("g0_put", 32'(buf_put), 1);
        chk("g0_data", 32'(buf_data), 8'h5A);
        req = '0; req_put = '0;
        tick(); chk("g0_release", 32'(grant), 0);
        tick();

        // holder 1: a foreign strobe is ignored, own strobe forwarded
        req = 3'b010; tick();
        chk("g1_grant", 32'(grant), 3'b010);
        req_put = 3'b100; req_data = 24'hFF0000;
        #1 chk("foreign_put", 32'(buf_put), 0);
        req_put = 3'b010; req_data = 24'h00A500;
        #1 chk("holder_put", 32'(buf_put), 1);
        chk("holder_data", 32'(buf_data), 8'hA5);

        // reset while holding: grant drops at once, pointer back to 0
        reset = 1'b1; tick();
        chk("rst_mid_grant", 32'(grant), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        reset = 1'b0; req = 3'b110; req_put = '0; tick();
        chk("post_rst_grant", 32'(grant), 3'b010);
        chk("post_rst_id", 32'(gnt_id), 1);
        req = '0; tick(); tick();

        // full round robin with dead cycles
        reset = 1'b1; tick(); reset = 1'b0;
        req = 3'b111; req_put = 3'b111; req_data = 24'h332211;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("rr_grant", 32'(grant), 1 << ord[j]);
            chk("rr_id", 32'(gnt_id), ord[j]);
            repeat (3) begin
                tick();
                chk("rr_hold", 32'(grant), 1 << ord[j]);
            end
            req[ord[j]] = 1'b0;
            #1 chk("drop_put_fwd", 32'(buf_put), 1);
            tick(); chk("rr_release", 32'(grant), 0);
            req[ord[j]] = 1'b1;
            tick(); chk("rr_idle", 32'(grant), 0);
        end
        req = '0; req_put = '0; tick(); tick();

`ifdef USB_ARB_TIMEOUT_EN
        reset = 1'b1; tick(); reset = 1'b0;
        req = 3'b001; req_put = '0;
        tick(); chk("to_grant", 32'(grant), 3'b001);
        repeat (3) begin
            tick(); chk("to_hold", 32'(grant), 3'b001);
        end
        tick();
        chk("to_pulse", 32'(timeout), 1);
        chk("to_drop", 32'(grant), 0);
        tick(); chk("to_pulse_end", 32'(timeout), 0);
        repeat (3) begin
            tick(); chk("to_no_regrant", 32'(grant), 0);
        end
        req = '0; tick();
        req = 3'b001; tick();
        chk("to_regrant", 32'(grant), 3'b001);
        req = '0; tick(); tick();
`endif

        // two requesters, pointer wrap
        reset = 1'b1; tick(); reset = 1'b0;
        req2 = 2'b01; put2 = 2'b11; data2 = 16'hBBAA;
        tick(); chk("w2_first", 32'(grant2), 2'b01);
        req2 = '0; tick(); tick();
        req2 = 2'b11;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("w2_grant", 32'(grant2), 1 << ord2[j]);
            chk("w2_id", 32'(gnt_id2), ord2[j]);
            chk("w2_data", 32'(buf_data2), (ord2[j] == 1) ? 8'hBB : 8'hAA);
            req2[ord2[j]] = 1'b0;
            tick(); chk("w2_release", 32'(grant2), 0);
            req2[ord2[j]] = 1'b1;
            tick(); chk("w2_idle", 32'(grant2), 0);
        end
        req2 = '0; put2 = '0; tick();

        // randomized traffic against the model
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            end
            req_put  = N'($urandom);
            req_data = 24'($urandom);
            reset    = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; req = '0; req_put = '0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
